// File: rtl/alu_pkg.sv
// Shared opcode, error-bit and entry-format definitions for the ALU result stage.
package alu_pkg;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_RST    = 4'b0001;
  localparam logic [3:0] OP_ILL_LO = 4'b0010;
  localparam logic [3:0] OP_NOT    = 4'b0011;
  localparam logic [3:0] OP_MUL    = 4'b1010;
  localparam logic [3:0] OP_ADD    = 4'b1011;
  localparam logic [3:0] OP_SUB    = 4'b1100;
  localparam logic [3:0] OP_DIV    = 4'b1101;
  localparam logic [3:0] OP_MOD    = 4'b1110;
  localparam logic [3:0] OP_ILL_HI = 4'b1111;

  localparam int ERR_OVF  = 0;
  localparam int ERR_DIV0 = 1;
  localparam int STK_ILL  = 2;

  localparam int ENTRY_W = 38;

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_RST,
    CLS_ILL,
    CLS_ALU
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    if (op == OP_NOP) return CLS_NOP;
    if (op == OP_RST) return CLS_RST;
    if (op == OP_ILL_LO || op == OP_ILL_HI) return CLS_ILL;
    return CLS_ALU;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// In-order result FIFO; head holds the last shown entry while empty.
module result_fifo #(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 38
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] last_q, last_d;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      // Remember the popped entry so head stays stable once the FIFO drains.
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the 16-bit ALU: accumulator, sticky errors,
// saturating op counter and a buffered valid/ready result stream.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          opcode,
  input  logic [31:0]         result,
  input  logic [1:0]          err_in,
  output logic [31:0]         acc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ENTRY_W-1:0]  out_data,
  output logic [2:0]          sticky_err,
  output logic [CNT_W-1:0]    op_count
);

  logic [31:0]        acc_q, acc_d;
  logic [2:0]         sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push, pop, full, empty, accept;
  logic [ENTRY_W-1:0] push_data;

  assign in_ready   = !full;
  assign accept     = in_valid && in_ready;
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  assign acc        = acc_q;
  assign sticky_err = sticky_q;
  assign op_count   = cnt_q;

  always_comb begin
    acc_d     = acc_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = '0;
    if (accept) begin
      case (op_class(opcode))
        CLS_RST: begin
          acc_d    = '0;
          sticky_d = '0;
        end
        CLS_ILL: begin
          sticky_d[STK_ILL] = 1'b1;
          push              = 1'b1;
          push_data         = {opcode, 2'b00, 32'h0};
        end
        CLS_ALU: begin
          // Error results are still loaded; the flags only travel alongside.
          acc_d                    = result;
          sticky_d[ERR_DIV0:ERR_OVF] = sticky_q[ERR_DIV0:ERR_OVF] | err_in;
          push                     = 1'b1;
          push_data                = {opcode, err_in, result};
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  result_fifo #(
    .DEPTH  (DEPTH),
    .ENTRY_W(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (out_data)
  );

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed tests for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

  localparam int CW = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [31:0] result;
  logic [1:0]  err_in;
  logic [31:0] acc;
  logic        out_valid;
  logic        out_ready;
  logic [37:0] out_data;
  logic [2:0]  sticky_err;
  logic [CW-1:0] op_count;

  int errors = 0;
  int checks = 0;

  alu_result_stage #(.DEPTH(2), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .result    (result),
    .err_in    (err_in),
    .acc       (acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sticky_err(sticky_err),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] res, input logic [1:0] e);
    in_valid = 1'b1;
    opcode   = op;
    result   = res;
    err_in   = e;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    opcode   = 4'h0;
    result   = 32'h0;
    err_in   = 2'b00;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    apply_reset();
    checks++; if (acc !== 32'h0) begin errors++; $display("FAIL reset_acc got %h want 0", acc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 38'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (sticky_err !== 3'b000) begin errors++; $display("FAIL reset_sticky got %b want 000", sticky_err); end
    checks++; if (op_count !== 3'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(4'b1011, 32'h0000_5609, 2'b00);
    tick();
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b want 1", out_valid); end
    checks++; if (out_data !== {4'b1011, 2'b00, 32'h0000_5609}) begin errors++; $display("FAIL add_out_data got %h want %h", out_data, {4'b1011, 2'b00, 32'h0000_5609}); end
    checks++; if (acc !== 32'h0000_5609) begin errors++; $display("FAIL add_acc got %h want 00005609", acc); end
    checks++; if (op_count !== 3'd1) begin errors++; $display("FAIL add_op_count got %0d want 1", op_count); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain_valid got %b want 0", out_valid); end
    checks++; if (out_data !== {4'b1011, 2'b00, 32'h0000_5609}) begin errors++; $display("FAIL add_hold_data got %h want %h", out_data, {4'b1011, 2'b00, 32'h0000_5609}); end
  endtask

  task automatic test_mul_nop();
    out_ready = 1'b1;
    drive(4'b1010, 32'h0040_1000, 2'b00);
    tick();
    checks++; if (out_data !== {4'b1010, 2'b00, 32'h0040_1000}) begin errors++; $display("FAIL mul_out_data got %h want %h", out_data, {4'b1010, 2'b00, 32'h0040_1000}); end
    drive(4'b0000, 32'hDEAD_BEEF, 2'b00);
    tick();
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nop_no_push got valid %b want 0", out_valid); end
    checks++; if (acc !== 32'h0040_1000) begin errors++; $display("FAIL nop_acc got %h want 00401000", acc); end
    checks++; if (op_count !== 3'd2) begin errors++; $display("FAIL nop_op_count got %0d want 2", op_count); end
  endtask

  task automatic test_div_mod_reset();
    out_ready = 1'b1;
    apply_reset();
    drive(4'b1101, 32'h0, 2'b10);
    tick();
    checks++; if (sticky_err !== 3'b010) begin errors++; $display("FAIL div_sticky got %b want 010", sticky_err); end
    checks++; if (out_data !== {4'b1101, 2'b10, 32'h0}) begin errors++; $display("FAIL div_out_data got %h want %h", out_data, {4'b1101, 2'b10, 32'h0}); end
    drive(4'b1110, 32'h7, 2'b00);
    tick();
    checks++; if (sticky_err !== 3'b010) begin errors++; $display("FAIL mod_sticky got %b want 010", sticky_err); end
    checks++; if (acc !== 32'h7) begin errors++; $display("FAIL mod_acc got %h want 7", acc); end
    drive(4'b0001, 32'hFFFF_FFFF, 2'b11);
    tick();
    idle();
    checks++; if (acc !== 32'h0) begin errors++; $display("FAIL rstop_acc got %h want 0", acc); end
    checks++; if (sticky_err !== 3'b000) begin errors++; $display("FAIL rstop_sticky got %b want 000", sticky_err); end
    checks++; if (op_count !== 3'd2) begin errors++; $display("FAIL rstop_op_count got %0d want 2", op_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstop_no_push got valid %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b0;
    drive(4'b1011, 32'h1, 2'b00);
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", in_ready); end
    drive(4'b1100, 32'h2, 2'b01);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got in_ready %b want 0", in_ready); end
    drive(4'b0011, 32'h3, 2'b00);
    tick();
    checks++; if (op_count !== 3'd2) begin errors++; $display("FAIL b2b_held_count got %0d want 2", op_count); end
    checks++; if (acc !== 32'h2) begin errors++; $display("FAIL b2b_held_acc got %h want 2", acc); end
    checks++; if (out_data !== {4'b1011, 2'b00, 32'h1}) begin errors++; $display("FAIL b2b_head_a got %h want %h", out_data, {4'b1011, 2'b00, 32'h1}); end
    out_ready = 1'b1;
    tick();
    checks++; if (op_count !== 3'd2) begin errors++; $display("FAIL b2b_full_pop_count got %0d want 2", op_count); end
    checks++; if (out_data !== {4'b1100, 2'b01, 32'h2}) begin errors++; $display("FAIL b2b_head_b got %h want %h", out_data, {4'b1100, 2'b01, 32'h2}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_space got in_ready %b want 1", in_ready); end
    tick();
    idle();
    checks++; if (op_count !== 3'd3) begin errors++; $display("FAIL b2b_c_count got %0d want 3", op_count); end
    checks++; if (out_data !== {4'b0011, 2'b00, 32'h3}) begin errors++; $display("FAIL b2b_head_c got %h want %h", out_data, {4'b0011, 2'b00, 32'h3}); end
    checks++; if (sticky_err !== 3'b001) begin errors++; $display("FAIL b2b_sticky got %b want 001", sticky_err); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(4'b1111, 32'h1234, 2'b11);
    tick();
    checks++; if (out_data !== {4'b1111, 2'b00, 32'h0}) begin errors++; $display("FAIL ill_out_data got %h want %h", out_data, {4'b1111, 2'b00, 32'h0}); end
    checks++; if (sticky_err !== 3'b101) begin errors++; $display("FAIL ill_sticky got %b want 101", sticky_err); end
    checks++; if (op_count !== 3'd3) begin errors++; $display("FAIL ill_op_count got %0d want 3", op_count); end
    checks++; if (acc !== 32'h3) begin errors++; $display("FAIL ill_acc got %h want 3", acc); end
    drive(4'b0010, 32'h55, 2'b00);
    tick();
    idle();
    checks++; if (out_data !== {4'b0010, 2'b00, 32'h0}) begin errors++; $display("FAIL ill2_out_data got %h want %h", out_data, {4'b0010, 2'b00, 32'h0}); end
    tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(4'b1011, 32'(i), 2'b00);
      tick();
    end
    idle();
    checks++; if (op_count !== 3'd7) begin errors++; $display("FAIL sat_op_count got %0d want 7", op_count); end
    checks++; if (acc !== 32'd8) begin errors++; $display("FAIL sat_acc got %h want 8", acc); end
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b0;
    drive(4'b1100, 32'h1, 2'b00);
    tick();
    drive(4'b1011, 32'h0000_5609, 2'b00);
    tick();
    idle();
    checks++; if (acc !== 32'h0000_5609 || in_ready !== 1'b0) begin errors++; $display("FAIL arst_setup got acc %h in_ready %b want 00005609 0", acc, in_ready); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    checks++; if (acc !== 32'h0) begin errors++; $display("FAIL arst_acc got %h want 0", acc); end
    checks++; if (out_data !== 38'h0) begin errors++; $display("FAIL arst_out_data got %h want 0", out_data); end
    checks++; if (op_count !== 3'd0) begin errors++; $display("FAIL arst_op_count got %0d want 0", op_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_discard got %b want 0", out_valid); end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    idle();
    test_reset();
    test_add();
    test_mul_nop();
    test_div_mod_reset();
    test_back_to_back();
    test_illegal();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
